// File: rtl/board_reset_sequencer_pkg.sv
// Shared types and default timing constants for the board reset sequencer.
package board_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'd0,
    LOCK_STABLE = 2'd1,
    HOLD        = 2'd2,
    RUN         = 2'd3
  } seq_state_t;

  localparam int DEBOUNCE_CYCLES_DEF    = 20000;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int RESET_HOLD_CYCLES_DEF  = 16;
  localparam int HEARTBEAT_BIT_DEF      = 22;

endpackage

// File: rtl/board_reset_sequencer_debounce.sv
// Two-flop synchronizer plus debouncer: clean_o follows raw_i once the synced
// value has differed for DEBOUNCE_CYCLES cycles (2 + DEBOUNCE_CYCLES latency).
module debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic clean_o
);

  localparam int             CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            clean_q;
  logic            clean_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q >= CntMax) ? cnt_q : cnt_q + CntW'(1);
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_inc >= CntMax) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/board_reset_sequencer.sv
// Core reset sequencer: lock qualify -> hold -> run, plus debounced switch/buttons.
// Optional run heartbeat counter is built only when HEARTBEAT_EN is defined.
module board_reset_sequencer
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int RESET_HOLD_CYCLES  = RESET_HOLD_CYCLES_DEF,
  parameter int HEARTBEAT_BIT      = HEARTBEAT_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       sw_rst_raw,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_clean,
  output logic       core_reset,
  output logic       ready,
  output logic [1:0] seq_state,
  output logic       heartbeat
);

  localparam int              StW     = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int              HoldW   = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [StW-1:0]  StMax   = StW'(LOCK_STABLE_CYCLES);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD_CYCLES);

  logic             lock_sync1_q;
  logic             locked_s;
  logic             sw_clean;
  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [StW-1:0]   stable_cnt_q;
  logic [StW-1:0]   stable_cnt_d;
  logic [StW-1:0]   stable_inc;
  logic [HoldW-1:0] hold_cnt_q;
  logic [HoldW-1:0] hold_cnt_d;
  logic [HoldW-1:0] hold_inc;
  logic             core_reset_q;
  logic             core_reset_d;
  logic             ready_q;
  logic             ready_d;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (sw_rst_raw),
    .clean_o(sw_clean)
  );

  for (genvar i = 0; i < 4; i++) begin : g_btn_db
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
      .clk_i  (clk),
      .rst_ni (reset),
      .raw_i  (btn_raw[i]),
      .clean_o(btn_clean[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_sync1_q <= 1'b0;
      locked_s     <= 1'b0;
      state_q      <= WAIT_LOCK;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      lock_sync1_q <= locked;
      locked_s     <= lock_sync1_q;
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    stable_inc   = (stable_cnt_q >= StMax) ? stable_cnt_q : stable_cnt_q + StW'(1);
    hold_inc     = (hold_cnt_q >= HoldMax) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        stable_cnt_d = '0;
        if (locked_s) state_d = LOCK_STABLE;
      end
      LOCK_STABLE: begin
        if (!locked_s) begin
          state_d      = WAIT_LOCK;
          stable_cnt_d = '0;
        end else if (stable_inc >= StMax) begin
          state_d      = HOLD;
          stable_cnt_d = '0;
          hold_cnt_d   = '0;
        end else begin
          stable_cnt_d = stable_inc;
        end
      end
      HOLD: begin
        // Lock loss outranks the switch, so a simultaneous press still drops to WAIT_LOCK.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (sw_clean) begin
          hold_cnt_d = '0;
        end else if (hold_inc >= HoldMax) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (sw_clean) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Registered from next state so core_reset moves on the very edge the state changes.
  always_comb begin
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign seq_state  = state_q;

`ifdef HEARTBEAT_EN
  localparam int HbW = HEARTBEAT_BIT + 1;

  logic [HbW-1:0] hb_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hb_q <= '0;
    end else if (state_q == RUN) begin
      hb_q <= hb_q + HbW'(1);
    end else begin
      hb_q <= '0;
    end
  end

  assign heartbeat = hb_q[HEARTBEAT_BIT];
`else
  assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Table-driven + scoreboard bench for board_reset_sequencer (small timing parameters).
module tb_board_reset_sequencer;

`ifdef HEARTBEAT_EN
  localparam bit HB_ON = 1'b1;
`else
  localparam bit HB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       sw_rst_raw;
  logic [3:0] btn_raw;
  logic [3:0] btn_clean;
  logic       core_reset;
  logic       ready;
  logic [1:0] seq_state;
  logic       heartbeat;

  board_reset_sequencer #(
    .DEBOUNCE_CYCLES   (4),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (3),
    .HEARTBEAT_BIT     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .sw_rst_raw(sw_rst_raw),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .core_reset(core_reset),
    .ready     (ready),
    .seq_state (seq_state),
    .heartbeat (heartbeat)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; outputs are sampled on the following falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic [1:0] st;
    logic [3:0] btn;
    bit         chk_hb;
    bit         hb;
  } exp_t;

  typedef struct {
    string      name;
    bit         rst_n;
    bit         lk;
    bit         sw;
    logic [3:0] btn;
    int         n;
    logic [1:0] st;
    logic [3:0] btnc;
    bit         chk_hb;
    bit         hb;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic sb_push(input int due, input string nm, input logic [1:0] st,
                         input logic [3:0] btn, input bit chk_hb, input bit hb);
    exp_t e;
    e.due    = due;
    e.name   = nm;
    e.st     = st;
    e.btn    = btn;
    e.chk_hb = chk_hb;
    e.hb     = hb;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s.%s at cycle %0d: got %0d, expected %0d", nm, fld, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin : pop_blk
      exp_t e;
      e = exp_q.pop_front();
      if (e.due < cyc) begin
        cmp(e.name, "due_cycle", cyc, e.due);
      end else begin
        cmp(e.name, "seq_state", int'(seq_state), int'(e.st));
        cmp(e.name, "core_reset", int'(core_reset), int'(e.st != 2'd3));
        cmp(e.name, "ready", int'(ready), int'(e.st == 2'd3));
        cmp(e.name, "btn_clean", int'(btn_clean), int'(e.btn));
        if (e.chk_hb) cmp(e.name, "heartbeat", int'(heartbeat), int'(e.hb & HB_ON));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[11];
  int   c;

  initial begin
    reset      = 1'b0;
    locked     = 1'b0;
    sw_rst_raw = 1'b0;
    btn_raw    = 4'h0;

    // Power-up: lock driven high at cycle 5, reaches RUN at 19, heartbeat rises 8 later.
    vt[0]  = '{"reset",            1'b0, 1'b0, 1'b0, 4'h0, 2, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[1]  = '{"wait_lock",        1'b1, 1'b0, 1'b0, 4'h0, 3, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[2]  = '{"lock_sync_lat",    1'b1, 1'b1, 1'b0, 4'h0, 2, 2'd0, 4'h0, 1'b0, 1'b0};
    vt[3]  = '{"lock_stable_in",   1'b1, 1'b1, 1'b0, 4'h0, 1, 2'd1, 4'h0, 1'b0, 1'b0};
    vt[4]  = '{"lock_stable_last", 1'b1, 1'b1, 1'b0, 4'h0, 7, 2'd1, 4'h0, 1'b0, 1'b0};
    vt[5]  = '{"hold_in",          1'b1, 1'b1, 1'b0, 4'h0, 1, 2'd2, 4'h0, 1'b0, 1'b0};
    vt[6]  = '{"hold_last",        1'b1, 1'b1, 1'b0, 4'h0, 2, 2'd2, 4'h0, 1'b1, 1'b0};
    vt[7]  = '{"run_in",           1'b1, 1'b1, 1'b0, 4'h0, 1, 2'd3, 4'h0, 1'b1, 1'b0};
    vt[8]  = '{"hb_low",           1'b1, 1'b1, 1'b0, 4'h0, 7, 2'd3, 4'h0, 1'b1, 1'b0};
    vt[9]  = '{"hb_rise",          1'b1, 1'b1, 1'b0, 4'h0, 1, 2'd3, 4'h0, 1'b1, 1'b1};
    vt[10] = '{"hb_wrap",          1'b1, 1'b1, 1'b0, 4'h0, 8, 2'd3, 4'h0, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      reset      = vt[i].rst_n;
      locked     = vt[i].lk;
      sw_rst_raw = vt[i].sw;
      btn_raw    = vt[i].btn;
      sb_push(cyc + vt[i].n, vt[i].name, vt[i].st, vt[i].btnc, vt[i].chk_hb, vt[i].hb);
      tick(vt[i].n);
    end

    // Switch glitch of 3 cycles in RUN: must not leave RUN.
    c = cyc;
    sb_push(c + 7,  "sw_glitch_a", 2'd3, 4'h0, 1'b0, 1'b0);
    sb_push(c + 10, "sw_glitch_b", 2'd3, 4'h0, 1'b0, 1'b0);
    sw_rst_raw = 1'b1;
    tick(3);
    sw_rst_raw = 1'b0;
    tick(7);

    // Switch held 10 cycles: clean after 6, HOLD on the next edge, RUN 6+3 after release.
    c = cyc;
    sb_push(c + 6,  "sw_pre_hold",  2'd3, 4'h0, 1'b0, 1'b0);
    sb_push(c + 7,  "sw_hold",      2'd2, 4'h0, 1'b0, 1'b0);
    sw_rst_raw = 1'b1;
    sb_push(c + 15, "sw_still_hold", 2'd2, 4'h0, 1'b0, 1'b0);
    sb_push(c + 18, "sw_hold_last", 2'd2, 4'h0, 1'b0, 1'b0);
    sb_push(c + 19, "sw_rerun",     2'd3, 4'h0, 1'b0, 1'b0);
    tick(10);
    sw_rst_raw = 1'b0;
    tick(10);

    // Buttons: 0101 appears after 6 cycles; 1-cycle glitch on bit 3 is filtered.
    c = cyc;
    sb_push(c + 5,  "btn_pre",     2'd3, 4'h0, 1'b0, 1'b0);
    sb_push(c + 6,  "btn_set",     2'd3, 4'h5, 1'b1, 1'b0);
    sb_push(c + 7,  "btn_hb_rise", 2'd3, 4'h5, 1'b1, 1'b1);
    sb_push(c + 12, "btn_glitch",  2'd3, 4'h5, 1'b0, 1'b0);
    sb_push(c + 15, "btn_hold",    2'd3, 4'h5, 1'b0, 1'b0);
    sb_push(c + 16, "btn_release", 2'd3, 4'h0, 1'b0, 1'b0);
    btn_raw = 4'b0101;
    tick(2);
    btn_raw = 4'b1101;
    tick(1);
    btn_raw = 4'b0101;
    tick(7);
    btn_raw = 4'b0000;
    tick(7);

    // Lock loss with switch pressed in RUN: WAIT_LOCK wins.
    c = cyc;
    sb_push(c + 2, "lockloss_pre", 2'd3, 4'h0, 1'b0, 1'b0);
    sb_push(c + 3, "lockloss",     2'd0, 4'h0, 1'b1, 1'b0);
    locked     = 1'b0;
    sw_rst_raw = 1'b1;
    tick(8);
    sw_rst_raw = 1'b0;
    sb_push(c + 17, "lockloss_wait", 2'd0, 4'h0, 1'b0, 1'b0);
    tick(10);

    // Lock jitter: high 5, low 1, high again -> qualification restarts.
    c = cyc;
    sb_push(c + 7,  "jit_stable",   2'd1, 4'h0, 1'b0, 1'b0);
    sb_push(c + 8,  "jit_drop",     2'd0, 4'h0, 1'b0, 1'b0);
    sb_push(c + 9,  "jit_restart",  2'd1, 4'h0, 1'b0, 1'b0);
    sb_push(c + 16, "jit_last",     2'd1, 4'h0, 1'b0, 1'b0);
    sb_push(c + 17, "jit_hold",     2'd2, 4'h0, 1'b0, 1'b0);
    sb_push(c + 19, "jit_hold_end", 2'd2, 4'h0, 1'b0, 1'b0);
    sb_push(c + 20, "jit_run",      2'd3, 4'h0, 1'b1, 1'b0);
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(14);

    // Mid-run reset for one cycle clears state, heartbeat and buttons.
    c = cyc;
    sb_push(c + 6,  "mr_btn",      2'd3, 4'h3, 1'b0, 1'b0);
    sb_push(c + 8,  "mr_pre",      2'd3, 4'h3, 1'b1, 1'b1);
    sb_push(c + 9,  "mr_reset",    2'd0, 4'h0, 1'b1, 1'b0);
    sb_push(c + 11, "mr_wait",     2'd0, 4'h0, 1'b0, 1'b0);
    sb_push(c + 12, "mr_relock",   2'd1, 4'h0, 1'b0, 1'b0);
    sb_push(c + 14, "mr_btn_pre",  2'd1, 4'h0, 1'b0, 1'b0);
    sb_push(c + 15, "mr_btn_back", 2'd1, 4'h3, 1'b0, 1'b0);
    btn_raw = 4'b0011;
    tick(8);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(7);

    tick(3);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
